mul8_seq_ctrl: RTL

MUL8_SEQ_CTRL -- requirements
Module: mul8_seq_ctrl

---
 rtl/mul8_pkg.sv | 27 ++
 rtl/mul8_row.sv | 20 ++
 rtl/mul8_seq_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mul8_pkg.sv
// mul8_pkg: shared widths, derived constants and FSM state type for the
// sequential 8x8 shift-and-add multiplier (mul8_seq_ctrl, mul8_row).
package mul8_pkg;

    // Operand and product widths
    localparam int MUL_W     = 8;
    localparam int PROD_W    = 16;

    // Width of a partial-product row index (rows 0..MUL_W-1)
    localparam int ROW_IDX_W = $clog2(MUL_W);

    // Row counter width: one extra bit so it can reach MUL_W after the last step
    localparam int CNT_W     = ROW_IDX_W + 1;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Number of CALC cycles needed for a full operand at a given row rate
    function automatic int calc_cycles(input int rows_per_cycle);
        return MUL_W / rows_per_cycle;
    endfunction

endpackage

// File: rtl/mul8_row.sv
// mul8_row: one shifted partial-product row, (a AND {8{b_bit}}) << row,
// zero-extended to the product width.
module mul8_row
    import mul8_pkg::*;
(
    input  logic [MUL_W-1:0]     a_val,
    input  logic                 b_bit,
    input  logic [ROW_IDX_W-1:0] row,
    output logic [PROD_W-1:0]    row_val
);

    logic [PROD_W-1:0] gated;

    // Gate the multiplicand by the multiplier bit, then weight it by the row position
    always_comb begin
        gated   = {{(PROD_W-MUL_W){1'b0}}, a_val & {MUL_W{b_bit}}};
        row_val = gated << row;
    end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// mul8_seq_ctrl: sequential unsigned 8x8 multiplier. Accepts an operand pair
// in IDLE, accumulates ROWS_PER_CYCLE partial-product rows per CALC cycle,
// then presents the registered product on y with a one-cycle done pulse.
// Optional feature macro: MUL8_EARLY_EXIT_EN -- finish as soon as no set
// multiplier bits remain above the rows already accumulated.
module mul8_seq_ctrl
    import mul8_pkg::*;
#(
    parameter int ROWS_PER_CYCLE = 1   // legal values: 1, 2, 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MUL_W-1:0]  a,
    input  logic [MUL_W-1:0]  b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] y
);

    // Counter step per CALC cycle and the row index that starts the final step
    localparam logic [CNT_W-1:0] STEP     = CNT_W'(ROWS_PER_CYCLE);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MUL_W - ROWS_PER_CYCLE);

    state_t            state;
    state_t            state_next;
    logic [MUL_W-1:0]  a_reg;
    logic [MUL_W-1:0]  b_reg;
    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] acc_next;
    logic [CNT_W-1:0]  row_idx;
    logic [PROD_W-1:0] rows [ROWS_PER_CYCLE];
    logic              finish;

    // One row generator per row handled in a cycle, at offsets row_idx + i
    for (genvar i = 0; i < ROWS_PER_CYCLE; i++) begin : g_row
        logic [ROW_IDX_W-1:0] row_sel;

        assign row_sel = row_idx[ROW_IDX_W-1:0] + ROW_IDX_W'(i);

        mul8_row u_row (
            .a_val   (a_reg),
            .b_bit   (b_reg[row_sel]),
            .row     (row_sel),
            .row_val (rows[i])
        );
    end

    // Sum of the accumulator and every row produced this cycle
    always_comb begin
        // NOTE: blocking assignments are right here: each loop pass builds on the previous partial sum within the same evaluation.
        acc_next = acc;
        for (int i = 0; i < ROWS_PER_CYCLE; i++) begin
            acc_next = acc_next + rows[i];
        end
    end

`ifdef MUL8_EARLY_EXIT_EN
    logic [CNT_W-1:0] row_end;

    // The sum is final once no multiplier bit at or above the next row is set
    assign row_end = row_idx + STEP;
    assign finish  = (row_idx == LAST_IDX) || ((b_reg >> row_end) == '0);
`else
    // Fixed latency: finish only on the step that covers row MUL_W-1
    assign finish  = (row_idx == LAST_IDX);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs, decoded from the state register only
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (finish) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, accumulation, row counter and product register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            row_idx <= '0;
            y       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        acc     <= '0;
                        row_idx <= '0;
                    end
                end
                CALC: begin
                    acc     <= acc_next;
                    row_idx <= row_idx + STEP;
                    if (finish) begin
                        y <= acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
